// File: rtl/cram_pkg.sv
// cram_pkg: shared constants and types for the cartridge RAM DRAM scheduler.
//   RA_W       DRAM multiplexed address width
//   S_*        phase-counter slot start values
//   owner_e    which user owns the DRAM in the current half-cycle slot
//   s_sat_inc  saturating increment of the phase counter
package cram_pkg;

   localparam int unsigned RA_W = 12;

   // Refresh and DMA share the low-half slot, so both start at S1.
   localparam logic [3:0] S_REF     = 4'd1;
   localparam logic [3:0] S_DMA     = 4'd1;
   localparam logic [3:0] S_CPU     = 4'd4;
   localparam logic [3:0] S_CPU_CAS = 4'd6;
   localparam logic [3:0] S_MAX     = 4'd15;

   typedef enum logic [1:0] {IDLE, REF, DMA, CPU} owner_e;

   function automatic logic [3:0] s_sat_inc(input logic [3:0] s);
      return (s == S_MAX) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/cram_phase_sync.sv
// cram_phase_sync: tracks the C64 PHI2 phase in DotClk cycles.
// Ports:
//   i_dotclk   dot clock (8 per PHI2 cycle)
//   i_res      async active-high reset
//   i_phi2     C64 phase-2 clock (sampled)
//   o_s        phase counter S (0 = not yet synchronised, 1..7 slots, saturates at 15)
//   o_s_next   value S takes on the next DotClk edge
//   o_fall     PHI2 falling edge seen on this sample (S reloads to 1)
module cram_phase_sync
   import cram_pkg::*;
(
   input  logic       i_dotclk,
   input  logic       i_res,
   input  logic       i_phi2,
   output logic [3:0] o_s,
   output logic [3:0] o_s_next,
   output logic       o_fall
);

   logic       r_phi2_prev;
   logic       r_seen_low;
   logic [3:0] r_s;
   logic       w_seen_low;
   logic       w_fall;
   logic [3:0] w_s_next;

   // Includes the current sample so the first low sample already counts.
   assign w_seen_low = r_seen_low | ~i_phi2;
   assign w_fall     = ~i_phi2 & r_phi2_prev;

   always_comb begin
      w_s_next = r_s;
      if (!w_seen_low) begin
         w_s_next = 4'd0;
      end else if (w_fall) begin
         w_s_next = S_REF;
      end else begin
         w_s_next = s_sat_inc(r_s);
      end
   end

   always_ff @(posedge i_dotclk or posedge i_res) begin
      if (i_res) begin
         r_phi2_prev <= 1'b0;
         r_seen_low  <= 1'b0;
         r_s         <= 4'd0;
      end else begin
         r_phi2_prev <= i_phi2;
         r_seen_low  <= w_seen_low;
         r_s         <= w_s_next;
      end
   end

   assign o_s      = r_s;
   assign o_s_next = w_s_next;
   assign o_fall   = w_fall & w_seen_low;

endmodule

// File: rtl/cram_dram_sched.sv
// cram_dram_sched: DRAM access scheduler for the cartridge RAM board.
// Low half of each PHI2 cycle (S1..S3): CAS-before-RAS refresh or DMA access.
// High half (S4..S7): guaranteed CPU access slot.
// Optional feature macro: CRAM_DMA_EN (undefined: DMA port ignored, dma_ack/dma_rdata = 0).
// Ports:
//   DotClk, RES, PHI2               clock, async active-high reset, C64 phase-2
//   cpu_req/we/addr/wdata/ack/rdata CPU request port (req held until ack)
//   dma_req/we/addr/wdata/ack/rdata DMA request port (same rules)
//   RA, nRAS, nCAS, nRWE            DRAM address and active-low strobes
//   RDo, RDoe, RDi                  DRAM write data, its drive enable, read data
// All DRAM-side outputs are registered: values for slot k are computed from the
// next phase value and loaded on the edge that enters slot k.
module cram_dram_sched
   import cram_pkg::*;
#(
   parameter int unsigned REF_DIV = 8,
   parameter int unsigned ADDR_W  = 22
) (
   input  logic              DotClk,
   input  logic              RES,
   input  logic              PHI2,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   output logic              dma_ack,
   output logic [7:0]        dma_rdata,
   output logic [RA_W-1:0]   RA,
   output logic              nRAS,
   output logic              nCAS,
   output logic              nRWE,
   output logic [7:0]        RDo,
   output logic              RDoe,
   input  logic [7:0]        RDi
);

`ifdef CRAM_DMA_EN
   localparam bit DmaEn = 1'b1;
`else
   localparam bit DmaEn = 1'b0;
`endif

   function automatic logic [RA_W-1:0] ra_row(input logic [ADDR_W-1:0] a);
      return {1'b0, 11'(a >> 11)};
   endfunction

   function automatic logic [RA_W-1:0] ra_col(input logic [ADDR_W-1:0] a);
      return {1'b0, a[10:0]};
   endfunction

   logic [3:0]        w_s;
   logic [3:0]        w_s_next;
   logic              w_fall;
   logic              w_abort;

   owner_e            r_own,       w_own_d;
   logic [ADDR_W-1:0] r_addr,      w_addr_d;
   logic              r_we,        w_we_d;
   logic [7:0]        r_wdata,     w_wdata_d;
   logic [3:0]        r_ref_cnt,   w_ref_d;
   logic [RA_W-1:0]   r_ra,        w_ra_d;
   logic              r_nras,      w_nras_d;
   logic              r_ncas,      w_ncas_d;
   logic              r_nrwe,      w_nrwe_d;
   logic              r_rdoe,      w_rdoe_d;
   logic [7:0]        r_rdo,       w_rdo_d;
   logic              r_cpu_ack,   w_cpu_ack_d;
   logic [7:0]        r_cpu_rdata, w_cpu_rdata_d;
   logic              r_dma_ack,   w_dma_ack_d;
   logic [7:0]        r_dma_rdata, w_dma_rdata_d;

   cram_phase_sync u_phase (
      .i_dotclk (DotClk),
      .i_res    (RES),
      .i_phi2   (PHI2),
      .o_s      (w_s),
      .o_s_next (w_s_next),
      .o_fall   (w_fall)
   );

   // Early PHI2 fall while a strobe sequence may be running (S1..S6): drop it.
   assign w_abort = w_fall && (w_s >= S_REF) && (w_s <= S_CPU_CAS);

   always_comb begin
      w_nras_d      = 1'b1;
      w_ncas_d      = 1'b1;
      w_nrwe_d      = 1'b1;
      w_rdoe_d      = 1'b0;
      w_rdo_d       = 8'h00;
      w_ra_d        = r_ra;
      w_own_d       = r_own;
      w_addr_d      = r_addr;
      w_we_d        = r_we;
      w_wdata_d     = r_wdata;
      w_ref_d       = r_ref_cnt;
      w_cpu_ack_d   = 1'b0;
      w_cpu_rdata_d = r_cpu_rdata;
      w_dma_ack_d   = 1'b0;
      w_dma_rdata_d = r_dma_rdata;

      if (w_abort) begin
         w_own_d = IDLE;
      end else begin
         case (w_s_next)
            S_REF: begin
               if (r_ref_cnt == 4'd0) begin
                  w_own_d  = REF;
                  w_ncas_d = 1'b0;
               end else if (DmaEn && dma_req) begin
                  w_own_d   = DMA;
                  w_addr_d  = dma_addr;
                  w_we_d    = dma_we;
                  w_wdata_d = dma_wdata;
                  w_ra_d    = ra_row(dma_addr);
               end else begin
                  w_own_d = IDLE;
               end
            end
            S_REF + 4'd1: begin
               if (r_own == REF) begin
                  w_ncas_d = 1'b0;
                  w_nras_d = 1'b0;
               end else if (r_own == DMA) begin
                  w_ra_d   = ra_row(r_addr);
                  w_nras_d = 1'b0;
               end
            end
            S_REF + 4'd2: begin
               if (r_own == DMA) begin
                  w_ra_d   = ra_col(r_addr);
                  w_nras_d = 1'b0;
                  w_ncas_d = 1'b0;
                  w_nrwe_d = ~r_we;
                  w_rdoe_d = r_we;
                  w_rdo_d  = r_we ? r_wdata : 8'h00;
               end
            end
            S_CPU: begin
               if (r_own == DMA) begin
                  w_dma_ack_d   = 1'b1;
                  w_dma_rdata_d = RDi;
               end
               w_ref_d = (r_ref_cnt == 4'(REF_DIV - 1)) ? 4'd0 : r_ref_cnt + 4'd1;
               if (cpu_req) begin
                  w_own_d   = CPU;
                  w_addr_d  = cpu_addr;
                  w_we_d    = cpu_we;
                  w_wdata_d = cpu_wdata;
                  w_ra_d    = ra_row(cpu_addr);
               end else begin
                  w_own_d = IDLE;
               end
            end
            S_CPU + 4'd1: begin
               if (r_own == CPU) begin
                  w_ra_d   = ra_row(r_addr);
                  w_nras_d = 1'b0;
               end
            end
            S_CPU_CAS: begin
               if (r_own == CPU) begin
                  w_ra_d   = ra_col(r_addr);
                  w_nras_d = 1'b0;
                  w_ncas_d = 1'b0;
                  w_nrwe_d = ~r_we;
                  w_rdoe_d = r_we;
                  w_rdo_d  = r_we ? r_wdata : 8'h00;
               end
            end
            S_CPU_CAS + 4'd1: begin
               if (r_own == CPU) begin
                  w_cpu_ack_d   = 1'b1;
                  w_cpu_rdata_d = RDi;
               end
               w_own_d = IDLE;
            end
            default: begin
               w_own_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge DotClk or posedge RES) begin
      if (RES) begin
         r_own       <= IDLE;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= 8'h00;
         r_ref_cnt   <= 4'd0;
         r_ra        <= '0;
         r_nras      <= 1'b1;
         r_ncas      <= 1'b1;
         r_nrwe      <= 1'b1;
         r_rdoe      <= 1'b0;
         r_rdo       <= 8'h00;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_dma_ack   <= 1'b0;
         r_dma_rdata <= 8'h00;
      end else begin
         r_own       <= w_own_d;
         r_addr      <= w_addr_d;
         r_we        <= w_we_d;
         r_wdata     <= w_wdata_d;
         r_ref_cnt   <= w_ref_d;
         r_ra        <= w_ra_d;
         r_nras      <= w_nras_d;
         r_ncas      <= w_ncas_d;
         r_nrwe      <= w_nrwe_d;
         r_rdoe      <= w_rdoe_d;
         r_rdo       <= w_rdo_d;
         r_cpu_ack   <= w_cpu_ack_d;
         r_cpu_rdata <= w_cpu_rdata_d;
         r_dma_ack   <= w_dma_ack_d;
         r_dma_rdata <= w_dma_rdata_d;
      end
   end

   assign RA        = r_ra;
   assign nRAS      = r_nras;
   assign nCAS      = r_ncas;
   assign nRWE      = r_nrwe;
   assign RDo       = r_rdo;
   assign RDoe      = r_rdoe;
   assign cpu_ack   = r_cpu_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_ack   = DmaEn & r_dma_ack;
   assign dma_rdata = DmaEn ? r_dma_rdata : 8'h00;

endmodule

// File: tb/tb_cram_dram_sched.sv
// tb_cram_dram_sched: directed, table-driven bench for cram_dram_sched.
// PHI2 is generated from DotClk (4 high, 4 low); the bench predicts the slot
// number and the refresh counter on its own from its PHI2 phase.
module tb_cram_dram_sched;

   localparam int unsigned REF_DIV = 8;
   localparam int unsigned ADDR_W  = 22;
`ifdef CRAM_DMA_EN
   localparam bit DmaEn = 1'b1;
`else
   localparam bit DmaEn = 1'b0;
`endif

   logic              DotClk    = 1'b0;
   logic              RES       = 1'b1;
   logic              PHI2      = 1'b1;
   logic              cpu_req   = 1'b0;
   logic              cpu_we    = 1'b0;
   logic [ADDR_W-1:0] cpu_addr  = '0;
   logic [7:0]        cpu_wdata = 8'h00;
   logic              dma_req   = 1'b0;
   logic              dma_we    = 1'b0;
   logic [ADDR_W-1:0] dma_addr  = '0;
   logic [7:0]        dma_wdata = 8'h00;
   logic [7:0]        RDi       = 8'h00;
   logic              cpu_ack, dma_ack;
   logic [7:0]        cpu_rdata, dma_rdata;
   logic [11:0]       RA;
   logic              nRAS, nCAS, nRWE, RDoe;
   logic [7:0]        RDo;

   cram_dram_sched #(.REF_DIV(REF_DIV), .ADDR_W(ADDR_W)) dut (
      .DotClk    (DotClk),
      .RES       (RES),
      .PHI2      (PHI2),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata),
      .RA        (RA),
      .nRAS      (nRAS),
      .nCAS      (nCAS),
      .nRWE      (nRWE),
      .RDo       (RDo),
      .RDoe      (RDoe),
      .RDi       (RDi)
   );

   always #5 DotClk = ~DotClk;

   int phase   = 0;
   bit phi_run = 1'b0;
   always @(negedge DotClk) begin
      if (phi_run) begin
         phase = (phase + 1) % 8;
         PHI2  = (phase < 4);
      end
   end

   int total = 0;
   int bad   = 0;
   int slot  = 0;
   bit synced = 1'b0;
   int ref_m = 0;

   typedef struct {
      logic        we;
      logic [21:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdi;
      logic [10:0] row;
      logic [10:0] col;
   } cpu_vec_t;
   cpu_vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (slot %0d)", name, act, exp, slot);
      end
   endtask

   // Falling PHI2 is seen at the posedge after phase 4 starts: that edge enters S1.
   task automatic tick();
      @(posedge DotClk);
      #1;
      if (phi_run && phase == 4) synced = 1'b1;
      slot = synced ? ((phase + 4) % 8) + 1 : 0;
      if (slot == 4) ref_m = (ref_m + 1) % REF_DIV;
   endtask

   task automatic wait_slot(input int k);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (slot != k && n < 40);
      if (slot != k) begin
         total++;
         bad++;
         $display("FAIL wait_slot: slot %0d not reached, at %0d", k, slot);
      end
   endtask

   initial begin
      int n_ack;
      int n_cbr;
      int n;

      vecs[0] = '{1'b0, 22'h1234AB, 8'h00, 8'h5A, 11'h246, 11'h4AB};
      vecs[1] = '{1'b1, 22'h1234AB, 8'h3C, 8'hFF, 11'h246, 11'h4AB};
      vecs[2] = '{1'b0, 22'h3FFFFF, 8'h00, 8'hA5, 11'h7FF, 11'h7FF};
      vecs[3] = '{1'b1, 22'h000800, 8'hC3, 8'h00, 11'h001, 11'h000};
      vecs[4] = '{1'b0, 22'h0007FF, 8'h00, 8'h81, 11'h000, 11'h7FF};

      // Reset state, then PHI2 held high: nothing may start.
      repeat (3) tick();
      check("rst_nras", nRAS, 1);
      check("rst_ncas", nCAS, 1);
      check("rst_nrwe", nRWE, 1);
      check("rst_ra", RA, 0);
      check("rst_rdoe", RDoe, 0);
      check("rst_rdo", RDo, 0);
      check("rst_acks", {cpu_ack, dma_ack}, 0);
      check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
      RES = 1'b0;
      repeat (12) tick();
      check("hold_s", dut.w_s, 0);
      check("hold_nras", nRAS, 1);
      check("hold_ncas", nCAS, 1);
      check("hold_ack", cpu_ack, 0);

      phi_run = 1'b1;
      synced  = 1'b0;
      ref_m   = 0;

      // First low half after reset is a CBR refresh.
      wait_slot(1);
      check("ref0_s1_ncas", nCAS, 0);
      check("ref0_s1_nras", nRAS, 1);
      tick();
      check("ref0_s2_nras", nRAS, 0);
      tick();
      check("ref0_s3_ncas", nCAS, 1);

      // CPU accesses from the vector table.
      for (int i = 0; i < 5; i++) begin
         wait_slot(2);
         cpu_req   = 1'b1;
         cpu_we    = vecs[i].we;
         cpu_addr  = vecs[i].addr;
         cpu_wdata = vecs[i].wdata;
         RDi       = vecs[i].rdi;
         wait_slot(4);
         check("cpu_s4_ra", RA, {1'b0, vecs[i].row});
         check("cpu_s4_nras", nRAS, 1);
         check("cpu_s4_ack", cpu_ack, 0);
         tick();
         check("cpu_s5_ra", RA, {1'b0, vecs[i].row});
         check("cpu_s5_nras", nRAS, 0);
         check("cpu_s5_ncas", nCAS, 1);
         check("cpu_s5_rdo", RDo, 0);
         tick();
         check("cpu_s6_ra", RA, {1'b0, vecs[i].col});
         check("cpu_s6_nras", nRAS, 0);
         check("cpu_s6_ncas", nCAS, 0);
         check("cpu_s6_nrwe", nRWE, !vecs[i].we);
         check("cpu_s6_rdoe", RDoe, vecs[i].we);
         check("cpu_s6_rdo", RDo, vecs[i].we ? vecs[i].wdata : 8'h00);
         tick();
         check("cpu_s7_ack", cpu_ack, 1);
         check("cpu_s7_rdata", cpu_rdata, vecs[i].rdi);
         check("cpu_s7_strobes", {nRAS, nCAS, nRWE, RDoe}, 4'b1110);
         check("cpu_s7_rdo", RDo, 0);
         cpu_req = 1'b0;
         tick();
         check("cpu_s8_ack", cpu_ack, 0);
         check("cpu_s8_rdata", cpu_rdata, vecs[i].rdi);
      end

      // DMA held for REF_DIV PHI2 cycles: one CBR refresh, DMA in the others.
      wait_slot(8);
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_addr = 22'h2AB123;
      RDi      = 8'h77;
      n_ack    = 0;
      n_cbr    = 0;
      for (int c = 0; c < 8 * REF_DIV; c++) begin
         tick();
         if (slot == 1) begin
            check("dma_s1_ncas", nCAS, (ref_m == 0) ? 0 : 1);
            check("dma_s1_nras", nRAS, 1);
            if (!nCAS && nRAS) n_cbr++;
         end
         if (slot == 2) check("dma_s2_nras", nRAS, (ref_m == 0 || DmaEn) ? 0 : 1);
         if (slot == 3 && ref_m != 0 && DmaEn) check("dma_s3_ra", RA, 12'h123);
         if (dma_ack) begin
            n_ack++;
            check("dma_ack_slot", slot, 4);
            check("dma_rdata", dma_rdata, 8'h77);
         end
      end
      dma_req = 1'b0;
      check("dma_ack_count", n_ack, DmaEn ? REF_DIV - 1 : 0);
      check("cbr_count", n_cbr, 1);
      check("dma_rdata_off", dma_rdata, DmaEn ? 8'h77 : 8'h00);

      // CPU and DMA in the same PHI2 cycle, on a non-refresh low half.
      n = 0;
      do begin
         wait_slot(8);
         n++;
      end while (ref_m == 0 && n < 4);
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 22'h0F0F0F;
      dma_req   = 1'b1;
      dma_we    = 1'b1;
      dma_addr  = 22'h2AB123;
      dma_wdata = 8'h96;
      RDi       = 8'hE7;
      tick();
      if (DmaEn) check("mix_s1_ra", RA, 12'h556);
      check("mix_s1_strobes", {nRAS, nCAS}, 2'b11);
      tick();
      check("mix_s2_nras", nRAS, DmaEn ? 0 : 1);
      check("mix_s2_ncas", nCAS, 1);
      tick();
      check("mix_s3_ncas", nCAS, DmaEn ? 0 : 1);
      check("mix_s3_nrwe", nRWE, DmaEn ? 0 : 1);
      check("mix_s3_rdo", RDo, DmaEn ? 8'h96 : 8'h00);
      if (DmaEn) check("mix_s3_ra", RA, 12'h123);
      tick();
      check("mix_s4_dma_ack", dma_ack, DmaEn);
      check("mix_s4_strobes", {nRAS, nCAS, RDoe}, 3'b110);
      check("mix_s4_ra", RA, 12'h1E1);
      dma_req = 1'b0;
      tick();
      check("mix_s5_nras", nRAS, 0);
      check("mix_s5_dma_ack", dma_ack, 0);
      tick();
      check("mix_s6_ncas", nCAS, 0);
      check("mix_s6_nrwe", nRWE, 1);
      check("mix_s6_ra", RA, 12'h70F);
      tick();
      check("mix_s7_cpu_ack", cpu_ack, 1);
      check("mix_s7_rdata", cpu_rdata, 8'hE7);
      check("mix_s7_dma_ack", dma_ack, 0);
      cpu_req = 1'b0;

      // RES pulse at S5 of a CPU read: strobes drop at once, served after resync.
      wait_slot(2);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 22'h1234AB;
      RDi      = 8'h11;
      wait_slot(5);
      check("res_s5_active", nRAS, 0);
      #1;
      RES = 1'b1;
      #1;
      check("res_async_nras", nRAS, 1);
      check("res_async_ncas", nCAS, 1);
      check("res_async_ra", RA, 0);
      check("res_async_rdata", cpu_rdata, 0);
      #1;
      RES    = 1'b0;
      synced = 1'b0;
      ref_m  = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("res_no_ack", cpu_ack, 0);
         check("res_nras_high", nRAS, 1);
      end
      wait_slot(1);
      check("res_resync_ref", nCAS, 0);
      wait_slot(7);
      check("res_served_ack", cpu_ack, 1);
      check("res_served_rdata", cpu_rdata, 8'h11);
      cpu_req = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
